decade_scan_ctrl: RTL and testbench



---
 rtl/decade_scan_ctrl_if.sv | 13 +
 rtl/decade_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_decade_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decade_scan_ctrl_if.sv
// rtl/decade_scan_ctrl_if.sv - digit stream between scan controller and sink
interface decade_scan_ctrl_if #(
    parameter int IW = 2
);
    logic          valid;
    logic          ready;
    logic [3:0]    digit;
    logic [IW-1:0] idx;
    logic          last;

    modport master (output valid, output digit, output idx, output last, input ready);
    modport slave  (input valid, input digit, input idx, input last, output ready);
endinterface

// File: rtl/decade_scan_ctrl.sv
// rtl/decade_scan_ctrl.sv - prescaled BCD counter with 2421 digit scan stream
module decade_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 10,
    parameter int IW     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic                start,
    decade_scan_ctrl_if.master  sink,
    output logic                busy,
    output logic [4*DIGITS-1:0] bcd,
    output logic                wrap
);
    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic [4*DIGITS-1:0] inc;
    logic [IW-1:0]       idx_q, idx_d;
    logic                roll_q, roll_d;
    logic                wrap_q, wrap_d;
    logic                tick;
    logic                carry;
    logic                all_nines;
    logic [3:0]          sel;

    assign tick = en && (pre_q == PRE_LAST);
    assign bcd  = bcd_q;
    assign wrap = wrap_q;

    // Decimal ripple increment, prescaler step and wrap pipeline; clr beats tick
    always_comb begin
        carry     = tick;
        all_nines = 1'b1;
        inc       = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    inc[4*i +: 4] = 4'd0;
                end else begin
                    inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        pre_d  = pre_q;
        bcd_d  = bcd_q;
        roll_d = 1'b0;
        wrap_d = 1'b0;
        if (clr) begin
            pre_d = '0;
            bcd_d = '0;
        end else begin
            wrap_d = roll_q;
            if (en) begin
                pre_d = tick ? '0 : pre_q + 1'b1;
            end
            if (tick) begin
                bcd_d  = inc;
                roll_d = all_nines;
            end
        end
    end

    // Count-side registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            bcd_q  <= '0;
            roll_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            bcd_q  <= bcd_d;
            roll_q <= roll_d;
            wrap_q <= wrap_d;
        end
    end

    // Scan state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan next state: start only honoured in IDLE, leave SEND after last transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_SEND;
            S_SEND: if (sink.ready && (idx_q == IDX_LAST)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Snapshot the live count on an accepted start, advance idx on each transfer
    always_comb begin
        snap_d = snap_q;
        idx_d  = idx_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                snap_d = bcd_q;
                idx_d  = '0;
            end
        end else if (sink.ready) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Snapshot and index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
            idx_q  <= '0;
        end else begin
            snap_q <= snap_d;
            idx_q  <= idx_d;
        end
    end

    // Stream outputs from registers through the single shared 2421 converter
    always_comb begin
        sel = snap_q[3:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                sel = snap_q[4*i +: 4];
            end
        end
        sink.valid = (state_q == S_SEND);
        busy       = (state_q == S_SEND);
        sink.idx   = idx_q;
        sink.last  = (state_q == S_SEND) && (idx_q == IDX_LAST);
        sink.digit = (sel > 4'd4) ? sel + 4'd6 : sel;
    end
endmodule

// File: tb/tb_decade_scan_ctrl.sv
// tb/tb_decade_scan_ctrl.sv - scoreboard bench for decade_scan_ctrl
module tb_decade_scan_ctrl;
    localparam int D    = 4;
    localparam int DV   = 3;
    localparam int IWP  = 2;
    localparam int MAXC = 9999;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           clr;
    logic           start;
    logic           busy;
    logic           wrap;
    logic [4*D-1:0] bcd;

    decade_scan_ctrl_if #(.IW(IWP)) sif();

    decade_scan_ctrl #(.DIGITS(D), .DIV(DV), .IW(IWP)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (clr),
        .start (start),
        .sink  (sif),
        .busy  (busy),
        .bcd   (bcd),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        int         i;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_cnt    = 0;
    int         m_pre    = 0;
    int         m_left   = 0;
    logic       m_roll   = 1'b0;
    logic       m_wrap   = 1'b0;
    logic [3:0] code_tab [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    endtask

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int p;
        p = 1;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_digit(input int cnt, input int pos);
        int p;
        p = 1;
        for (int k = 0; k < pos; k++) p = p * 10;
        return code_tab[(cnt / p) % 10];
    endfunction

    task automatic step(input logic e, input logic c, input logic s, input logic r);
        @(posedge clk);
        #2;
        en        = e;
        clr       = c;
        start     = s;
        sif.ready = r;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, sif.valid, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_last"},  sif.last, 0);
        chk({tag, "_idx"},   sif.idx, 0);
        chk({tag, "_digit"}, sif.digit, 0);
        chk({tag, "_bcd"},   bcd, 0);
        chk({tag, "_wrap"},  wrap, 0);
    endtask

    // Reference model: integer count, prescaler phase and scan length
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cnt  = 0;
            m_pre  = 0;
            m_left = 0;
            m_roll = 1'b0;
            m_wrap = 1'b0;
            exp_q.delete();
        end else begin
            if (m_left > 0) begin
                if (sif.ready) m_left--;
            end else if (start) begin
                for (int i = 0; i < D; i++)
                    exp_q.push_back('{d: exp_digit(m_cnt, i), i: i, l: (i == D - 1)});
                m_left = D;
            end
            m_wrap = !clr && m_roll;
            m_roll = 1'b0;
            if (clr) begin
                m_cnt = 0;
                m_pre = 0;
            end else if (en) begin
                if (m_pre == DV - 1) begin
                    m_pre = 0;
                    if (m_cnt == MAXC) begin
                        m_cnt  = 0;
                        m_roll = 1'b1;
                    end else begin
                        m_cnt++;
                    end
                end else begin
                    m_pre++;
                end
            end
        end
    end

    // Monitor: compare every cycle, pop the scoreboard on each transfer
    initial forever begin
        @(negedge clk);
        chk("valid", sif.valid, 32'(m_left > 0));
        chk("busy", busy, 32'(m_left > 0));
        chk("bcd", bcd, to_bcd(m_cnt));
        chk("wrap", wrap, m_wrap);
        if (sif.valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_empty actual=valid required=no_valid t=%0t", $time);
            end else begin
                chk("digit", sif.digit, exp_q[0].d);
                chk("idx", sif.idx, exp_q[0].i);
                chk("last", sif.last, exp_q[0].l);
                if (sif.ready) exp_q.delete(0);
            end
        end else begin
            chk("last_idle", sif.last, 0);
        end
    end

    initial begin
        int   en_cnt;
        logic found;
        code_tab[0] = 4'b0000; code_tab[1] = 4'b0001; code_tab[2] = 4'b0010;
        code_tab[3] = 4'b0011; code_tab[4] = 4'b0100; code_tab[5] = 4'b1011;
        code_tab[6] = 4'b1100; code_tab[7] = 4'b1101; code_tab[8] = 4'b1110;
        code_tab[9] = 4'b1111;
        rst = 1'b1; en = 1'b0; clr = 1'b0; start = 1'b0; sif.ready = 1'b0;
        @(posedge clk);
        #1;
        chk_reset("por");
        @(posedge clk);
        #2;
        rst = 1'b0;

        repeat (50) step(0, 0, 0, 1);
        chk("en_off_bcd", bcd, 0);

        step(0, 1, 0, 1);
        repeat (9 * DV) step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("cnt9", bcd, 16'h0009);
        repeat (DV) step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("cnt10", bcd, 16'h0010);

        step(0, 1, 0, 1);
        repeat (MAXC * DV) step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("cnt9999", bcd, 16'h9999);
        repeat (DV) step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("roll_bcd", bcd, 16'h0000);
        chk("roll_wrap_edge", wrap, 0);
        step(0, 0, 0, 1);
        chk("wrap_pulse", wrap, 1);
        step(0, 0, 0, 1);
        chk("wrap_fall", wrap, 0);

        step(0, 1, 0, 1);
        en_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            logic e;
            e = 1'($urandom % 2);
            if (e) en_cnt++;
            step(e, 0, 0, 1);
        end
        step(0, 0, 0, 1);
        chk("presc_bcd", bcd, to_bcd(en_cnt / DV));

        for (int k = 0; k < 2 * DV && m_pre != DV - 1; k++) step(1, 0, 0, 1);
        en  = 1'b1;
        clr = 1'b1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("clr_tick_bcd", bcd, 0);
        repeat (DV) step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("clr_tick_pre", bcd, 16'h0001);

        step(0, 1, 0, 1);
        repeat (1589 * DV) step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("cnt1589", bcd, 16'h1589);
        step(0, 0, 1, 1);
        repeat (6) step(0, 0, 0, 1);

        step(1, 0, 1, 1);
        step(1, 0, 0, 1);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        chk("bp_idx", sif.idx, 1);
        chk("bp_valid", sif.valid, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 1, 1);
        repeat (3) step(0, 0, 0, 1);

        step(1, 0, 1, 1);
        step(1, 0, 0, 1);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (sif.valid && sif.idx == 2) found = 1'b1;
        end
        chk("idx2_seen", found, 1);
        #1;
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        @(posedge clk);
        #2;
        rst = 1'b0; start = 1'b0; en = 1'b0;
        repeat (2 * DV) step(1, 0, 0, 1);
        step(0, 0, 1, 1);
        repeat (6) step(0, 0, 0, 1);

        for (int k = 0; k < 3000; k++)
            step(1'($urandom % 2), 1'(($urandom % 100) == 0), 1'(($urandom % 4) == 0),
                 1'(($urandom % 3) != 0));
        repeat (8) step(0, 0, 0, 1);
        chk("sb_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
